// File: rtl/gbp_ftq_pkg.sv
// ============================================================================
// Module : gbp_ftq_pkg
// Brief  : Shared frontend types and widths for the gshare fetch-target queue.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package gbp_ftq_pkg;

  // Configuration widths of the surrounding frontend (global predictor, VA).
  localparam int unsigned c_gp_idx_w = 10;
  localparam int unsigned c_vlen     = 39;

  typedef struct packed {
    logic                  valid;
    logic                  resolved;
    logic                  pred_taken;
    logic                  act_taken;
    logic [c_gp_idx_w-1:0] index;
    logic [c_vlen-1:0]     pc;
  } ftq_entry_t;

endpackage

`default_nettype wire

// File: rtl/gbp_ftq.sv
// ============================================================================
// Module : gbp_ftq
// Brief  : In-order queue of gshare predictions awaiting resolution; retires
//          resolved heads as predictor updates.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gbp_ftq
  import gbp_ftq_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDX_W = c_gp_idx_w,
  parameter int unsigned VLEN  = c_vlen
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     debug_mode_i,
  input  logic                     push_valid_i,
  output logic                     push_ready_o,
  input  logic [VLEN-1:0]          push_pc_i,
  input  logic [IDX_W-1:0]         push_index_i,
  input  logic                     push_taken_i,
  output logic [$clog2(DEPTH)-1:0] push_id_o,
  input  logic                     resolve_valid_i,
  input  logic [$clog2(DEPTH)-1:0] resolve_id_i,
  input  logic                     resolve_taken_i,
  output logic                     resolve_mispredict_o,
  output logic                     update_valid_o,
  output logic [VLEN-1:0]          update_pc_o,
  output logic                     update_taken_o,
  output logic [IDX_W-1:0]         update_index_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned c_ptr_w = $clog2(DEPTH);
  localparam logic [c_ptr_w:0] c_ptr_one = {{c_ptr_w{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [c_ptr_w:0]   r_wr_ptr;
  logic [c_ptr_w:0]   r_rd_ptr;
  ftq_entry_t         r_ent [DEPTH];

  logic [c_ptr_w-1:0] w_wr_idx;
  logic [c_ptr_w-1:0] w_rd_idx;
  logic               w_full;
  logic               w_push;
  logic               w_res_ok;
  logic               w_pop;
  ftq_entry_t         w_head;
  ftq_entry_t         w_res_ent;

  assign w_wr_idx  = r_wr_ptr[c_ptr_w-1:0];
  assign w_rd_idx  = r_rd_ptr[c_ptr_w-1:0];
  assign w_full    = (w_wr_idx == w_rd_idx) && (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]);
  assign w_head    = r_ent[w_rd_idx];
  assign w_res_ent = r_ent[resolve_id_i];

  assign w_push   = push_valid_i && !w_full;
  assign w_res_ok = resolve_valid_i && w_res_ent.valid && !w_res_ent.resolved;
  assign w_pop    = w_head.valid && w_head.resolved;

  assign push_ready_o         = !w_full;
  assign push_id_o            = w_wr_idx;
  assign count_o              = r_wr_ptr - r_rd_ptr;
  assign resolve_mispredict_o = w_res_ok && (resolve_taken_i != w_res_ent.pred_taken);

  // A retiring head in debug mode still pops, it just never trains the table.
  assign update_valid_o = w_pop && !debug_mode_i && !flush_i;
  assign update_pc_o    = VLEN'(w_head.pc);
  assign update_index_o = IDX_W'(w_head.index);
  assign update_taken_o = w_head.act_taken;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_ent[i] <= '0;
      end
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_ent[i].valid    <= 1'b0;
        r_ent[i].resolved <= 1'b0;
      end
    end else begin
      // Push, resolve and pop always address distinct slots: a pushed slot is
      // empty, a resolvable slot is unresolved, a popped slot is resolved.
      if (w_push) begin
        r_ent[w_wr_idx].valid      <= 1'b1;
        r_ent[w_wr_idx].resolved   <= 1'b0;
        r_ent[w_wr_idx].pred_taken <= push_taken_i;
        r_ent[w_wr_idx].act_taken  <= 1'b0;
        r_ent[w_wr_idx].index      <= c_gp_idx_w'(push_index_i);
        r_ent[w_wr_idx].pc         <= c_vlen'(push_pc_i);
        r_wr_ptr                   <= r_wr_ptr + c_ptr_one;
      end
      if (w_res_ok) begin
        r_ent[resolve_id_i].resolved  <= 1'b1;
        r_ent[resolve_id_i].act_taken <= resolve_taken_i;
      end
      if (w_pop) begin
        r_ent[w_rd_idx].valid    <= 1'b0;
        r_ent[w_rd_idx].resolved <= 1'b0;
        r_rd_ptr                 <= r_rd_ptr + c_ptr_one;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gbp_ftq.sv
// ============================================================================
// Module : tb_gbp_ftq
// Brief  : Self-checking bench for gbp_ftq against a queue-based model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gbp_ftq;
  import gbp_ftq_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned IDX_W = c_gp_idx_w;
  localparam int unsigned VLEN  = c_vlen;
  localparam int unsigned IW    = $clog2(DEPTH);

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             flush_i, debug_mode_i;
  logic             push_valid_i, push_ready_o, push_taken_i;
  logic [VLEN-1:0]  push_pc_i;
  logic [IDX_W-1:0] push_index_i;
  logic [IW-1:0]    push_id_o;
  logic             resolve_valid_i, resolve_taken_i, resolve_mispredict_o;
  logic [IW-1:0]    resolve_id_i;
  logic             update_valid_o, update_taken_o;
  logic [VLEN-1:0]  update_pc_o;
  logic [IDX_W-1:0] update_index_o;
  logic [IW:0]      count_o;

  gbp_ftq #(.DEPTH(DEPTH), .IDX_W(IDX_W), .VLEN(VLEN)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .debug_mode_i(debug_mode_i),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o), .push_pc_i(push_pc_i),
    .push_index_i(push_index_i), .push_taken_i(push_taken_i), .push_id_o(push_id_o),
    .resolve_valid_i(resolve_valid_i), .resolve_id_i(resolve_id_i),
    .resolve_taken_i(resolve_taken_i), .resolve_mispredict_o(resolve_mispredict_o),
    .update_valid_o(update_valid_o), .update_pc_o(update_pc_o),
    .update_taken_o(update_taken_o), .update_index_o(update_index_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: an ordered list of in-flight predictions plus a tag counter.
  typedef struct {
    logic [VLEN-1:0]  pc;
    logic [IDX_W-1:0] idx;
    bit               pred;
    bit               res;
    bit               act;
    int               tag;
  } rec_t;

  rec_t m_q[$];
  int   m_wr;

  task automatic idle_inputs();
    flush_i = 0; debug_mode_i = 0; push_valid_i = 0; push_pc_i = '0;
    push_index_i = '0; push_taken_i = 0; resolve_valid_i = 0;
    resolve_id_i = '0; resolve_taken_i = 0;
  endtask

  // Compare this cycle's outputs against the model, advance the model, clock once.
  task automatic tick();
    int  j;
    bit  exp_misp, exp_upd, do_res, do_pop, do_push;
    j = -1;
    #1;
    for (int k = 0; k < m_q.size(); k++)
      if (m_q[k].tag == int'(resolve_id_i)) j = k;
    do_res   = resolve_valid_i && (j >= 0) && !m_q[j].res;
    exp_misp = do_res && (resolve_taken_i != m_q[j].pred);
    do_pop   = (m_q.size() > 0) && m_q[0].res;
    exp_upd  = do_pop && !debug_mode_i && !flush_i;
    do_push  = push_valid_i && (m_q.size() < int'(DEPTH));

    check_value("push_ready", push_ready_o, m_q.size() < int'(DEPTH));
    check_value("push_id", push_id_o, m_wr % DEPTH);
    check_value("count", count_o, m_q.size());
    check_value("mispredict", resolve_mispredict_o, exp_misp);
    check_value("update_valid", update_valid_o, exp_upd);
    if (exp_upd) begin
      check_value("update_pc", update_pc_o, m_q[0].pc);
      check_value("update_index", update_index_o, m_q[0].idx);
      check_value("update_taken", update_taken_o, m_q[0].act);
    end

    if (flush_i) begin
      m_q.delete();
      m_wr = 0;
    end else begin
      if (do_res) begin
        m_q[j].res = 1;
        m_q[j].act = resolve_taken_i;
      end
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        m_q.push_back('{pc: push_pc_i, idx: push_index_i, pred: push_taken_i,
                        res: 0, act: 0, tag: m_wr % DEPTH});
        m_wr = (m_wr + 1) % (2 * DEPTH);
      end
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic set_push(input logic [VLEN-1:0] pc, input logic [IDX_W-1:0] idx, input bit tk);
    push_valid_i = 1; push_pc_i = pc; push_index_i = idx; push_taken_i = tk;
  endtask

  task automatic set_resolve(input int id, input bit tk);
    resolve_valid_i = 1; resolve_id_i = IW'(id); resolve_taken_i = tk;
  endtask

  task automatic do_flush();
    idle_inputs(); flush_i = 1; tick(); idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_ni = 0;
    m_wr = 0;
    resolve_valid_i = 1;
    #3;
    check_value("rst_ready", push_ready_o, 1);
    check_value("rst_id", push_id_o, 0);
    check_value("rst_update", update_valid_o, 0);
    check_value("rst_count", count_o, 0);
    check_value("rst_misp", resolve_mispredict_o, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1;
    idle_inputs();

    // Fill to full, then an extra push must be dropped; drain to observe slot 0.
    for (int i = 0; i < 9; i++) begin
      idle_inputs(); set_push(VLEN'(32'h100 + 4 * i), IDX_W'(i + 1), i[0]); tick();
    end
    idle_inputs();
    check_value("full_ready", push_ready_o, 0);
    check_value("full_count", count_o, DEPTH);
    for (int i = 0; i < 8; i++) begin
      idle_inputs(); set_resolve(i, 1); tick();
    end
    idle_inputs(); tick(); tick();
    do_flush();

    // Mispredicted single branch and its update payload.
    set_push(VLEN'(32'h1000), IDX_W'(8'h2A), 1); tick();
    idle_inputs(); set_resolve(0, 0);
    #1 check_value("dir_misp", resolve_mispredict_o, 1);
    tick();
    idle_inputs();
    #1 check_value("dir_upd_v", update_valid_o, 1);
    check_value("dir_upd_pc", update_pc_o, VLEN'(32'h1000));
    check_value("dir_upd_idx", update_index_o, IDX_W'(8'h2A));
    check_value("dir_upd_tk", update_taken_o, 0);
    tick();

    // Out-of-order resolve: younger resolved entry waits for the head.
    do_flush();
    set_push(VLEN'(32'h2000), IDX_W'(3), 0); tick();
    idle_inputs(); set_push(VLEN'(32'h2004), IDX_W'(4), 1); tick();
    idle_inputs(); set_resolve(1, 1); tick();
    idle_inputs(); tick(); tick();
    set_resolve(0, 1); tick();
    idle_inputs(); tick(); tick(); tick();

    // Flush with five entries plus a concurrent push and head resolve.
    do_flush();
    for (int i = 0; i < 5; i++) begin
      idle_inputs(); set_push(VLEN'(32'h3000 + 4 * i), IDX_W'(i), 1); tick();
    end
    idle_inputs(); set_resolve(0, 1); tick();
    idle_inputs(); set_push(VLEN'(32'h4000), IDX_W'(9), 0); set_resolve(1, 0); flush_i = 1;
    #1 check_value("flush_upd", update_valid_o, 0);
    check_value("flush_misp", resolve_mispredict_o, 1);
    tick();
    idle_inputs();
    #1 check_value("postflush_count", count_o, 0);
    check_value("postflush_upd", update_valid_o, 0);
    check_value("postflush_id", push_id_o, 0);
    tick();

    // Debug mode: head pops silently.
    set_push(VLEN'(32'h5000), IDX_W'(5), 0); tick();
    idle_inputs(); set_push(VLEN'(32'h5004), IDX_W'(6), 0); tick();
    idle_inputs(); set_resolve(0, 1); tick();
    idle_inputs(); debug_mode_i = 1;
    #1 check_value("dbg_upd", update_valid_o, 0);
    check_value("dbg_count_before", count_o, 2);
    tick();
    #1 check_value("dbg_count_after", count_o, 1);
    idle_inputs(); tick();

    // Wrap-around: steady-state push, resolve and pop every cycle.
    do_flush();
    for (int k = 0; k < 22; k++) begin
      idle_inputs();
      if (k < 20) set_push(VLEN'(32'h8000 + 4 * k), IDX_W'(k), k[1]);
      if (k >= 1 && k < 21) set_resolve((k - 1) % DEPTH, k[0]);
      if (k < 20) begin
        #1 check_value("wrap_tag", push_id_o, k % DEPTH);
        if (k >= 2) check_value("wrap_count", count_o, 2);
      end
      tick();
    end
    idle_inputs(); tick();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      idle_inputs();
      if ($urandom_range(0, 99) < 55)
        set_push(VLEN'({$urandom, $urandom}), IDX_W'($urandom), $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 99) < 60) begin
        if (m_q.size() > 0 && $urandom_range(0, 9) < 7)
          set_resolve(m_q[$urandom_range(0, m_q.size() - 1)].tag, $urandom_range(0, 1) == 1);
        else
          set_resolve(int'($urandom_range(0, DEPTH - 1)), $urandom_range(0, 1) == 1);
      end
      debug_mode_i = ($urandom_range(0, 99) < 10);
      flush_i      = ($urandom_range(0, 99) < 2);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gbp_ftq.md
GBP_FTQ -- requirements
Module: gbp_ftq

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of in-flight prediction entries (power of 2, >=2).
REQ-002 SHALL have parameter IDX_W, default CVA6Cfg.GlobalPredictorIndexBits, width of the saved predictor index.
REQ-003 SHALL have parameter VLEN, default CVA6Cfg.VLEN, virtual PC width.
REQ-004 SHALL have port clk_i, input, 1, clock.
REQ-005 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port flush_i, input, 1, pipeline flush that drops all entries.
REQ-007 SHALL have port debug_mode_i, input, 1, suppresses predictor updates.
REQ-008 SHALL have port push_valid_i, input, 1, frontend offers one prediction record.
REQ-009 SHALL have port push_ready_o, output, 1, the queue can accept a record.
REQ-010 SHALL have push_pc_i (VLEN), push_index_i (IDX_W) and push_taken_i (1) as inputs: branch PC, gshare index used, predicted direction.
REQ-011 SHALL have port push_id_o, output, $clog2(DEPTH), slot tag assigned to the accepted record.
REQ-012 SHALL have resolve_valid_i (1), resolve_id_i ($clog2(DEPTH)) and resolve_taken_i (1) as inputs: execute resolution for a tag.
REQ-013 SHALL have port resolve_mispredict_o, output, 1, resolved direction differs from prediction.
REQ-014 SHALL have update_valid_o (1), update_pc_o (VLEN), update_taken_o (1) and update_index_o (IDX_W) as outputs: predictor update towards the gshare table.
REQ-015 SHALL have port count_o, output, $clog2(DEPTH)+1, occupied entries.

Function
REQ-016 SHALL implement a circular buffer with read and write pointers that each carry an extra wrap bit; full = same index with differing wrap bit; empty = pointers equal.
REQ-017 SHALL drive push_ready_o = !full, combinationally.
REQ-018 SHALL, on push_valid_i && push_ready_o, write pc/index/taken to slot wr_ptr, set valid=1 and resolved=0, and advance wr_ptr at the edge.
REQ-019 SHALL drive push_id_o = wr_ptr index at all times.
REQ-020 SHALL ignore a push while full: no state change and no overwrite.
REQ-021 SHALL, on resolve_valid_i to a slot with valid=1, set resolved=1 and store resolve_taken_i at the edge.
REQ-022 SHALL ignore a resolve to an invalid slot or an already-resolved slot; resolve_mispredict_o=0 in that case.
REQ-023 SHALL drive resolve_mispredict_o = resolve_valid_i && slot valid && !resolved && (resolve_taken_i != stored predicted taken), combinationally and in the same cycle.
REQ-024 SHALL pop the head slot when it is valid and resolved: clear valid and advance rd_ptr at the edge, one pop per cycle, strictly in order.
REQ-025 SHALL drive update_valid_o = head valid && head resolved && !debug_mode_i, combinationally from registered state; update_pc_o, update_index_o and update_taken_o (resolved direction) come from the head slot.
REQ-026 SHALL still pop a resolved head while debug_mode_i=1, without emitting update_valid_o.
REQ-027 SHALL make a resolve to the head at edge N visible as update_valid_o in cycle N+1; an unresolved head blocks all younger resolved entries.
REQ-028 SHALL accept a push and a pop in the same cycle; count_o is unchanged and pointers advance independently.
REQ-029 SHALL, on flush_i, clear all valid and resolved bits and set rw_ptr to 0 at the edge; flush has priority over simultaneous push, resolve and pop, and update_valid_o is forced 0 in the flush cycle.
REQ-030 SHALL keep resolve_mispredict_o and push_ready_o unaffected by flush_i in the flush cycle.
REQ-031 SHALL compute count_o as wr_ptr − rd_ptr modulo 2·DEPTH, registered-derived.

Reset
REQ-032 SHALL, on rst_ni low, asynchronously clear pointers and every valid/resolved bit; payload fields need no reset.
REQ-033 SHALL hold outputs in reset at: push_ready_o=1, push_id_o=0, update_valid_o=0, count_o=0, resolve_mispredict_o=0 (resolve gated by invalid slots).

Structure
REQ-034 SHALL define the entry typedef (valid, resolved, pred_taken, act_taken, index, pc) in the shared frontend package, parameterised via CVA6Cfg widths.
REQ-035 SHALL have no sub-module: storage is a flop array with inline pointer logic.

Verification
REQ-036 SHALL test reset then 8 pushes with DEPTH=8: push_ready_o=0 and count_o=8; a 9th push does not change slot 0.
REQ-037 SHALL test push pc=0x1000, idx=0x2A, taken=1, then resolve id0 taken=0: resolve_mispredict_o=1 in that cycle; next cycle update_valid_o=1, pc=0x1000, index=0x2A, taken=0.
REQ-038 SHALL test an out-of-order resolve of id1 before id0: no update is emitted until id0 resolves, then updates for id0 and id1 follow on consecutive cycles.
REQ-039 SHALL test flush with 5 entries, including a concurrent push and a resolve of the head: next cycle count_o=0, update_valid_o=0, push_id_o=0.
REQ-040 SHALL test a resolved head with debug_mode_i=1: update_valid_o stays 0 and count_o decrements by 1.
REQ-041 SHALL test wrap-around: 20 push/resolve/pop cycles with push and pop in the same cycle give count_o constant, and tags cycle through 0..7 twice plus 0..3.
